// File: rtl/cfg_serial_writer_if.sv
// cfg_serial_writer_if: host serial pins plus cfg byte-bus write outputs
interface cfg_serial_writer_if #(
  parameter int NUM_REGS = 6
);
  logic scs_n;
  logic sclk;
  logic sdata;
  logic [7:0] cfg_data;
  logic [NUM_REGS-1:0] cfg_en;
  logic busy;
  logic err;
  modport master(output scs_n, sclk, sdata, input cfg_data, cfg_en, busy, err);
  modport slave(input scs_n, sclk, sdata, output cfg_data, cfg_en, busy, err);
endinterface

// File: rtl/cfg_serial_writer.sv
// cfg_serial_writer: oversampled 3-wire host to cfg byte-bus writer; CFG_SERIAL_WRITER_PARITY_EN adds an odd parity bit per data byte
module cfg_serial_writer #(
  parameter int NUM_REGS = 6,
  parameter int ADDR_BITS = 3
) (
  input logic clk,
  input logic reset,
  cfg_serial_writer_if.slave bus
);
`ifdef CFG_SERIAL_WRITER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
  localparam int SW = 8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
  localparam int SW = 7;
`endif
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  state_t state, state_n;
  logic [1:0] scs_q, sclk_q, sdata_q;
  logic scs_d, sclk_d, srise, scs_fall, par_ok, err_n;
  logic [3:0] cnt, cnt_n;
  logic [SW-1:0] sh, sh_n;
  logic [7:0] nb, dbyte, data_n;
  logic [ADDR_BITS-1:0] addr, addr_n;
  logic [NUM_REGS-1:0] en_n;
  assign srise = sclk_q[1] & ~sclk_d;
  assign scs_fall = scs_d & ~scs_q[1];
  assign nb = {sh[6:0], sdata_q[1]};
`ifdef CFG_SERIAL_WRITER_PARITY_EN
  assign dbyte = sh;
  assign par_ok = ^{sh, sdata_q[1]};
`else
  assign dbyte = nb;
  assign par_ok = 1'b1;
`endif
  // sync chains reset low so a chip select held low across reset never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (reset) begin
      {scs_q, sclk_q, sdata_q, scs_d, sclk_d} <= '0;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      addr <= '0;
      bus.cfg_data <= '0;
      bus.cfg_en <= '0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      scs_q <= {scs_q[0], bus.scs_n};
      sclk_q <= {sclk_q[0], bus.sclk};
      sdata_q <= {sdata_q[0], bus.sdata};
      scs_d <= scs_q[1];
      sclk_d <= sclk_q[1];
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      addr <= addr_n;
      bus.cfg_data <= data_n;
      bus.cfg_en <= en_n;
      bus.busy <= state != IDLE;
      bus.err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    addr_n = addr;
    data_n = bus.cfg_data;
    en_n = '0;
    err_n = bus.err;
    case (state)
      IDLE: if (scs_fall) begin
        state_n = HEADER;
        cnt_n = '0;
        err_n = 1'b0;
      end
      HEADER: if (scs_q[1]) state_n = IDLE;
      else if (srise) begin
        sh_n = nb[SW-1:0];
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd7) begin
          addr_n = nb[7 -: ADDR_BITS];
          cnt_n = '0;
          state_n = DATA;
        end
      end
      DATA: if (scs_q[1]) state_n = IDLE;
      else if (srise) begin
        sh_n = (cnt < 4'd8) ? nb[SW-1:0] : sh;
        cnt_n = cnt + 4'd1;
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
          addr_n = (addr == ADDR_BITS'(NUM_REGS - 1)) ? '0 : addr + 1'b1;
          if ({1'b0, addr} < (ADDR_BITS + 1)'(NUM_REGS) && par_ok) begin
            en_n = NUM_REGS'(1) << addr;
            data_n = dbyte;
          end else err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cfg_serial_writer.sv
// tb_cfg_serial_writer: table-driven frames with a strobe scoreboard checking data, address and latency
module tb_cfg_serial_writer;
  localparam int NR = 6;
  typedef struct packed {
    logic [7:0] hdr;
    logic [2:0][7:0] d;
    logic [2:0][NR-1:0] en;
    logic [1:0] n;
    logic err;
  } vec_t;
  typedef struct packed {
    logic [NR-1:0] en;
    logic [7:0] data;
  } sb_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int last_rise = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] last_data = '0;
  sb_t sbq[$];
  sb_t exp_e;
  vec_t tbl[8];
  cfg_serial_writer_if #(.NUM_REGS(NR)) bus();
  cfg_serial_writer #(.NUM_REGS(NR), .ADDR_BITS(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && bus.cfg_en != '0) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got en=%b data=%h expected no strobe", bus.cfg_en, bus.cfg_data);
      end else begin
        exp_e = sbq.pop_front();
        chk("strobe_en", 32'(bus.cfg_en), 32'(exp_e.en));
        chk("strobe_data", 32'(bus.cfg_data), 32'(exp_e.data));
        chk("strobe_latency", 32'(cyc - last_rise), 32'd3);
      end
    end
  end
  function automatic vec_t mk(input logic [7:0] h, d0, d1, d2, input logic [NR-1:0] e0, e1, e2,
                              input logic [1:0] n, input logic err);
    vec_t v;
    v.hdr = h;
    v.d = {d2, d1, d0};
    v.en = {e2, e1, e0};
    v.n = n;
    v.err = err;
    return v;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bus.sdata = b;
    tick(4);
    bus.sclk = 1'b1;
    last_rise = cyc;
    tick(4);
    bus.sclk = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(b[i]);
  endtask
  task automatic send_data(input logic [7:0] d, input logic [NR-1:0] en);
    if (en != '0) begin
      sbq.push_back({en, d});
      last_data = d;
    end
    send_byte(d, 8);
`ifdef CFG_SERIAL_WRITER_PARITY_EN
    send_bit(~^d);
`endif
  endtask
  task automatic begin_frame();
    bus.scs_n = 1'b0;
    tick(6);
    chk("busy_in_frame", 32'(bus.busy), 32'd1);
    chk("err_cleared_on_fall", 32'(bus.err), 32'd0);
  endtask
  task automatic end_frame();
    tick(2);
    bus.scs_n = 1'b1;
    tick(8);
    chk("busy_after_deassert", 32'(bus.busy), 32'd0);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    begin_frame();
    send_byte(v.hdr, 8);
    for (int j = 0; j < int'(v.n); j++) send_data(v.d[j], v.en[j]);
    end_frame();
    chk($sformatf("vec%0d_err", idx), 32'(bus.err), 32'(v.err));
    chk($sformatf("vec%0d_pending_strobes", idx), 32'(sbq.size()), 32'd0);
    chk($sformatf("vec%0d_cfg_data_hold", idx), 32'(bus.cfg_data), 32'(last_data));
  endtask
  initial begin
    tbl[0] = mk(8'h40, 8'hA5, 8'h00, 8'h00, 6'b000100, 6'b0, 6'b0, 2'd1, 1'b0);
    tbl[1] = mk(8'hA0, 8'h11, 8'h22, 8'h33, 6'b100000, 6'b000001, 6'b000010, 2'd3, 1'b0);
    tbl[2] = mk(8'hE0, 8'h5A, 8'h00, 8'h00, 6'b0, 6'b0, 6'b0, 2'd1, 1'b1);
    tbl[3] = mk(8'h00, 8'hC3, 8'h3C, 8'h00, 6'b000001, 6'b000010, 6'b0, 2'd2, 1'b0);
    tbl[4] = mk(8'hDF, 8'h01, 8'h02, 8'h03, 6'b0, 6'b0, 6'b000001, 2'd3, 1'b1);
    tbl[5] = mk(8'h9F, 8'hFF, 8'h00, 8'h00, 6'b010000, 6'b100000, 6'b0, 2'd2, 1'b0);
    tbl[6] = mk(8'hE0, 8'h00, 8'h00, 8'h00, 6'b0, 6'b0, 6'b0, 2'd0, 1'b0);
    tbl[7] = mk(8'h20, 8'h77, 8'h00, 8'h00, 6'b000010, 6'b0, 6'b0, 2'd1, 1'b0);
    bus.scs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.sdata = 1'b0;
    tick(4);
    chk("reset_cfg_data", 32'(bus.cfg_data), 32'd0);
    chk("reset_cfg_en", 32'(bus.cfg_en), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick(4);
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);
    begin_frame();
    send_byte(8'h40, 8);
    send_byte(8'hFF, 5);
    end_frame();
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_cfg_data", 32'(bus.cfg_data), 32'(last_data));
    run_vec(tbl[7], 7);
    begin_frame();
    send_byte(8'h60, 8);
    send_byte(8'hFF, 4);
    reset = 1'b1;
    tick(2);
    chk("midreset_cfg_data", 32'(bus.cfg_data), 32'd0);
    chk("midreset_cfg_en", 32'(bus.cfg_en), 32'd0);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_err", 32'(bus.err), 32'd0);
    last_data = '0;
    reset = 1'b0;
    send_byte(8'hFF, 4);
    send_byte(8'h12, 8);
    tick(2);
    chk("postreset_ignored_busy", 32'(bus.busy), 32'd0);
    bus.scs_n = 1'b1;
    tick(8);
    chk("postreset_cfg_data", 32'(bus.cfg_data), 32'd0);
    run_vec(mk(8'h60, 8'h34, 8'h00, 8'h00, 6'b001000, 6'b0, 6'b0, 2'd1, 1'b0), 8);
`ifdef CFG_SERIAL_WRITER_PARITY_EN
    begin_frame();
    send_byte(8'h00, 8);
    sbq.push_back({6'b000001, 8'h03});
    last_data = 8'h03;
    send_byte(8'h03, 8);
    send_bit(1'b1);
    send_byte(8'h03, 8);
    send_bit(1'b0);
    send_data(8'h10, 6'b000100);
    end_frame();
    chk("parity_err", 32'(bus.err), 32'd1);
    chk("parity_pending_strobes", 32'(sbq.size()), 32'd0);
    chk("parity_cfg_data", 32'(bus.cfg_data), 32'h10);
`endif
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
